// File: rtl/wb_stage_if.sv
// MEM->WB handshake and register-file write bus for the write-back stage.
// The MEM side holds the master modport and the wb_stage holds the slave modport.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface wb_stage_if #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int REG_AW     = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  stall;
   logic                  flush;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [DATA_WIDTH-1:0] rdata;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic [DATA_WIDTH-1:0] imm;
   logic [1:0]            wb_sel;
   logic [2:0]            funct3;
   logic                  reg_write_in;
   logic [REG_AW-1:0]     rd_in;
   logic [DATA_WIDTH-1:0] rd_wdata;
   logic                  reg_write_out;
   logic [REG_AW-1:0]     rd_out;
   logic                  fwd_valid;

   modport master (
      output in_valid, stall, flush, alu_result, rdata, pc_plus4, imm,
             wb_sel, funct3, reg_write_in, rd_in,
      input  in_ready, rd_wdata, reg_write_out, rd_out, fwd_valid
   );

   modport slave (
      input  in_valid, stall, flush, alu_result, rdata, pc_plus4, imm,
             wb_sel, funct3, reg_write_in, rd_in,
      output in_ready, rd_wdata, reg_write_out, rd_out, fwd_valid
   );
endinterface

// File: rtl/wb_stage.sv
// Registered write-back stage: MEM/WB register, 4-way source mux, x0/kill gating, retire counter.
// Define WB_LOAD_ALIGN_EN to extract sub-word loads (funct3 + byte offset) on the MEM path.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_stage #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int REG_AW     = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_stage_if.slave            bus,
   output logic [CNT_WIDTH-1:0] retire_cnt
);

   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_MEM = 2'd1,
      SEL_PC4 = 2'd2,
      SEL_IMM = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic                  reg_write;
      logic [REG_AW-1:0]     rd;
      wb_sel_e               sel;
`ifdef WB_LOAD_ALIGN_EN
      logic [2:0]            funct3;
`endif
      logic [DATA_WIDTH-1:0] alu;
      logic [DATA_WIDTH-1:0] rdata;
      logic [DATA_WIDTH-1:0] pc4;
      logic [DATA_WIDTH-1:0] imm;
   } stage_t;

   stage_t                st;
   stage_t                st_in;
   logic                  valid;
   logic                  capture;
   logic                  commit;
   logic [DATA_WIDTH-1:0] mem_data;

   assign bus.in_ready = ~bus.stall;
   assign capture      = bus.in_valid & bus.in_ready;
   // A held entry commits only on the cycle stall drops, so it writes exactly once.
   assign commit       = valid & ~bus.stall & ~bus.flush;

   always_comb begin
      st_in           = '0;
      st_in.reg_write = bus.reg_write_in;
      st_in.rd        = bus.rd_in;
      st_in.sel       = wb_sel_e'(bus.wb_sel);
`ifdef WB_LOAD_ALIGN_EN
      st_in.funct3    = bus.funct3;
`endif
      st_in.alu       = bus.alu_result;
      st_in.rdata     = bus.rdata;
      st_in.pc4       = bus.pc_plus4;
      st_in.imm       = bus.imm;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // Flush outranks capture and stall; fields keep their value whenever no capture happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         st    <= '0;
      end else if (bus.flush) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         st    <= st_in;
      end else if (!bus.stall) begin
         valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (commit) begin
         retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      end
   end

`ifdef WB_LOAD_ALIGN_EN
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = st.rdata[{st.alu[1:0], 3'b000} +: 8];
      ld_half = st.alu[1] ? st.rdata[31:16] : st.rdata[15:0];
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      mem_data = st.rdata;
      case (st.funct3)
         3'b000:  mem_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  mem_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  mem_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         3'b101:  mem_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default: mem_data = st.rdata;
      endcase
   end
`else
   assign mem_data = st.rdata;
`endif

   always_comb begin
      bus.rd_wdata = st.alu;
      case (st.sel)
         SEL_ALU: bus.rd_wdata = st.alu;
         SEL_MEM: bus.rd_wdata = mem_data;
         SEL_PC4: bus.rd_wdata = st.pc4;
         SEL_IMM: bus.rd_wdata = st.imm;
         default: bus.rd_wdata = st.alu;
      endcase
   end

   assign bus.reg_write_out = commit & st.reg_write & (st.rd != '0);
   assign bus.fwd_valid     = bus.reg_write_out;
   assign bus.rd_out        = st.rd;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the source mux and load extraction,
// hand sequences for stall, flush, async reset and counter wrap (second instance, CNT_WIDTH=4).
`timescale 1ns/1ps

module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cnt32;
   logic [3:0]  cnt4;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = '0;

   always #5 clk = ~clk;

   wb_stage_if #(.DATA_WIDTH(32), .REG_AW(5)) bus ();
   wb_stage_if #(.DATA_WIDTH(32), .REG_AW(5)) bus4 ();

   wb_stage #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .retire_cnt(cnt32));

   wb_stage #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .retire_cnt(cnt4));

   assign bus4.in_valid     = bus.in_valid;
   assign bus4.stall        = bus.stall;
   assign bus4.flush        = bus.flush;
   assign bus4.alu_result   = bus.alu_result;
   assign bus4.rdata        = bus.rdata;
   assign bus4.pc_plus4     = bus.pc_plus4;
   assign bus4.imm          = bus.imm;
   assign bus4.wb_sel       = bus.wb_sel;
   assign bus4.funct3       = bus.funct3;
   assign bus4.reg_write_in = bus.reg_write_in;
   assign bus4.rd_in        = bus.rd_in;

   typedef struct {
      logic        v;
      logic [1:0]  sel;
      logic        rw;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] exp_wd;
      logic        exp_we;
      logic [4:0]  exp_rd;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic rw, input logic [4:0] rd);
      bus.in_valid     = v;
      bus.wb_sel       = sel;
      bus.reg_write_in = rw;
      bus.rd_in        = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        vt[16];
      logic        prev;
      logic [31:0] e_lb2, e_lbu2, e_lh2, e_lhu0, e_lb3, e_lbu1;

`ifdef WB_LOAD_ALIGN_EN
      e_lb2  = 32'hFFFF_FF81;
      e_lbu2 = 32'h0000_0081;
      e_lh2  = 32'hFFFF_8081;
      e_lhu0 = 32'h0000_7F80;
      e_lb3  = 32'hFFFF_FF80;
      e_lbu1 = 32'h0000_007F;
`else
      e_lb2  = 32'h8081_7F80;
      e_lbu2 = 32'h8081_7F80;
      e_lh2  = 32'h8081_7F80;
      e_lhu0 = 32'h8081_7F80;
      e_lb3  = 32'h8081_7F80;
      e_lbu1 = 32'h8081_7F80;
`endif

      //         v     sel   rw    rd     f3      alu            rdata          exp_wd         we    rd
      vt[0]  = '{1'b1, 2'd0, 1'b1, 5'd10, 3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hA1A1_A1A1, 1'b1, 5'd10};
      vt[1]  = '{1'b1, 2'd1, 1'b1, 5'd10, 3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hB2B2_B2B2, 1'b1, 5'd10};
      vt[2]  = '{1'b1, 2'd2, 1'b1, 5'd10, 3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 1'b1, 5'd10};
      vt[3]  = '{1'b1, 2'd3, 1'b1, 5'd10, 3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hD4D4_D4D4, 1'b1, 5'd10};
      vt[4]  = '{1'b1, 2'd0, 1'b1, 5'd0,  3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hA1A1_A1A1, 1'b0, 5'd0};
      vt[5]  = '{1'b1, 2'd3, 1'b1, 5'd31, 3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hD4D4_D4D4, 1'b1, 5'd31};
      vt[6]  = '{1'b1, 2'd0, 1'b0, 5'd5,  3'b010, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hA1A1_A1A1, 1'b0, 5'd5};
      vt[7]  = '{1'b0, 2'd2, 1'b1, 5'd7,  3'b010, 32'h1111_1111, 32'h2222_2222, 32'hA1A1_A1A1, 1'b0, 5'd5};
      vt[8]  = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b000, 32'h0000_1002, 32'h8081_7F80, e_lb2,         1'b1, 5'd12};
      vt[9]  = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b100, 32'h0000_1002, 32'h8081_7F80, e_lbu2,        1'b1, 5'd12};
      vt[10] = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b001, 32'h0000_1002, 32'h8081_7F80, e_lh2,         1'b1, 5'd12};
      vt[11] = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b101, 32'h0000_1000, 32'h8081_7F80, e_lhu0,        1'b1, 5'd12};
      vt[12] = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b000, 32'h0000_1003, 32'h8081_7F80, e_lb3,         1'b1, 5'd12};
      vt[13] = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b100, 32'h0000_1001, 32'h8081_7F80, e_lbu1,        1'b1, 5'd12};
      vt[14] = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b010, 32'h0000_1000, 32'h8081_7F80, 32'h8081_7F80, 1'b1, 5'd12};
      vt[15] = '{1'b1, 2'd1, 1'b1, 5'd12, 3'b011, 32'h0000_1002, 32'h8081_7F80, 32'h8081_7F80, 1'b1, 5'd12};

      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
      bus.pc_plus4   = 32'hC3C3_C3C3;
      bus.imm        = 32'hD4D4_D4D4;
      bus.alu_result = 32'hA1A1_A1A1;
      bus.rdata      = 32'hB2B2_B2B2;
      bus.funct3     = 3'b010;
      drive(1'b0, 2'd0, 1'b0, 5'd0);

      // Reset state
      #1;
      check("rst_we", 64'(bus.reg_write_out), 64'd0);
      check("rst_rd", 64'(bus.rd_out), 64'd0);
      check("rst_wdata", 64'(bus.rd_wdata), 64'd0);
      check("rst_cnt", 64'(cnt32), 64'd0);
      check("rst_ready", 64'(bus.in_ready), 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Table: back-to-back captures, each edge also commits the previous entry
      prev = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(vt[i].v, vt[i].sel, vt[i].rw, vt[i].rd);
         bus.funct3     = vt[i].f3;
         bus.alu_result = vt[i].alu;
         bus.rdata      = vt[i].rdata;
         tick();
         if (prev) exp_cnt++;
         check($sformatf("vec%0d_wdata", i), 64'(bus.rd_wdata), 64'(vt[i].exp_wd));
         check($sformatf("vec%0d_we", i), 64'(bus.reg_write_out), 64'(vt[i].exp_we));
         check($sformatf("vec%0d_fwd", i), 64'(bus.fwd_valid), 64'(vt[i].exp_we));
         check($sformatf("vec%0d_rd", i), 64'(bus.rd_out), 64'(vt[i].exp_rd));
         check($sformatf("vec%0d_cnt", i), 64'(cnt32), 64'(exp_cnt));
         check($sformatf("vec%0d_cnt4", i), 64'(cnt4), 64'(exp_cnt[3:0]));
         prev = vt[i].v;
      end
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      tick();
      if (prev) exp_cnt++;
      check("drain_cnt", 64'(cnt32), 64'(exp_cnt));
      check("drain_we", 64'(bus.reg_write_out), 64'd0);

      // Stall three cycles on a valid entry
      bus.alu_result = 32'hA1A1_A1A1;
      bus.rdata      = 32'hB2B2_B2B2;
      bus.funct3     = 3'b010;
      drive(1'b1, 2'd3, 1'b1, 5'd9);
      tick();
      check("stall_pre_we", 64'(bus.reg_write_out), 64'd1);
      bus.stall = 1'b1;
      drive(1'b1, 2'd0, 1'b1, 5'd11);
      #1;
      check("stall_we0", 64'(bus.reg_write_out), 64'd0);
      check("stall_ready", 64'(bus.in_ready), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("stall%0d_we", c), 64'(bus.reg_write_out), 64'd0);
         check($sformatf("stall%0d_rd", c), 64'(bus.rd_out), 64'd9);
         check($sformatf("stall%0d_wdata", c), 64'(bus.rd_wdata), 64'hD4D4_D4D4);
         check($sformatf("stall%0d_cnt", c), 64'(cnt32), 64'(exp_cnt));
      end
      bus.stall = 1'b0;
      #1;
      check("release_we", 64'(bus.reg_write_out), 64'd1);
      check("release_rd", 64'(bus.rd_out), 64'd9);
      check("release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      exp_cnt++;
      check("release_cnt", 64'(cnt32), 64'(exp_cnt));
      check("next_rd", 64'(bus.rd_out), 64'd11);
      check("next_wdata", 64'(bus.rd_wdata), 64'hA1A1_A1A1);
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      tick();
      exp_cnt++;
      check("next_cnt", 64'(cnt32), 64'(exp_cnt));

      // Flush with in_valid=1: entry is dropped
      drive(1'b1, 2'd0, 1'b1, 5'd14);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      #1;
      check("flush_we", 64'(bus.reg_write_out), 64'd0);
      tick();
      check("flush_cnt", 64'(cnt32), 64'(exp_cnt));

      // Flush during stall drops the held entry
      drive(1'b1, 2'd2, 1'b1, 5'd15);
      tick();
      bus.stall = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      tick();
      bus.flush = 1'b1;
      #1;
      check("fstall_we", 64'(bus.reg_write_out), 64'd0);
      tick();
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      #1;
      check("fstall_after_we", 64'(bus.reg_write_out), 64'd0);
      tick();
      check("fstall_cnt", 64'(cnt32), 64'(exp_cnt));

      // Asynchronous reset with a valid entry, no clock edge
      drive(1'b1, 2'd3, 1'b1, 5'd20);
      tick();
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      #1;
      check("mid_we_before", 64'(bus.reg_write_out), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_we", 64'(bus.reg_write_out), 64'd0);
      check("mid_cnt", 64'(cnt32), 64'd0);
      check("mid_cnt4", 64'(cnt4), 64'd0);
      check("mid_rd", 64'(bus.rd_out), 64'd0);
      exp_cnt = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // 16 commits: 4-bit counter wraps to 0, 32-bit counter reads 16
      drive(1'b1, 2'd0, 1'b1, 5'd3);
      for (int c = 0; c < 16; c++) tick();
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      tick();
      check("wrap_cnt4", 64'(cnt4), 64'd0);
      check("wrap_cnt32", 64'(cnt32), 64'd16);
      drive(1'b1, 2'd0, 1'b1, 5'd3);
      tick();
      drive(1'b0, 2'd0, 1'b0, 5'd0);
      tick();
      check("wrap_cnt4_next", 64'(cnt4), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
